dfs_lut_mc: RTL
===============

Name: dfs_lut_mc

Overview:
Multi-channel, parametrised DFS lookup table: the next generation of the single-port 18Kb frequency LUT. Several DFS controllers (one per channel) share one table through a round-robin arbitrated read port. The table holds saturating entries (default ramp 2..50), can be reprogrammed at runtime through a config write port, and clamps out-of-range addresses to the saturation value.

Parameters:
NCH, 4, number of requesting channels (1..16)
ADDR_WIDTH, 10, width of table address
DEPTH, 1024, number of table entries (<= 2**ADDR_WIDTH)
DATA_WIDTH, 16, entry width
OUT_REG, 1, 0 or 1: adds an output register stage after the array read
INIT_BASE, 2, entry value at index 0
INIT_STEP_X2, 5, twice the per-index increment
INIT_MAX, 50, saturation value; also returned for addr >= DEPTH

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
cfg_we  in  1  table write strobe
cfg_addr  in  ADDR_WIDTH  write address
cfg_data  in  DATA_WIDTH  write data
req_valid  in  NCH  per-channel read request
req_addr  in  NCH*ADDR_WIDTH  per-channel address, channel i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
req_ready  out  NCH  one-hot grant; the request is accepted when valid & ready
resp_valid  out  NCH  one-hot single-cycle response pulse, per channel
resp_data  out  DATA_WIDTH  shared response data, qualified by resp_valid

Behaviour:
- Reset: clk and reset only. reset=0 asynchronously clears resp_valid, resp_data, all pipeline valid bits and the RR pointer (to 0). Table contents are not affected by reset.
- Initial content (elaboration-time): entry[i] = min(INIT_BASE + (INIT_STEP_X2*i + 1)/2, INIT_MAX), integer division. The defaults give 2, 5, 7, 10, 12, ..., 47, 50, 50, ...
- Arbitration:
  - req_ready is combinational from req_valid, the RR pointer and cfg_we.
  - The grant goes to the first channel with req_valid=1, searching from the pointer upward and wrapping mod NCH.
  - After a grant, pointer = granted+1 mod NCH. With no request, the pointer holds.
  - At most one grant per cycle.
- Write priority: when cfg_we=1, all req_ready=0 that cycle and the entry at cfg_addr is written. A write with cfg_addr >= DEPTH is ignored.
- Read pipeline:
  - Accept in cycle T, synchronous array read at the edge ending T.
  - OUT_REG=0: resp_valid[ch] and resp_data appear in T+1.
  - OUT_REG=1: they appear in T+2.
  - Throughput is one response per cycle. There is no response backpressure; resp_valid lasts exactly one cycle.
- Out-of-range: an accepted addr >= DEPTH returns INIT_MAX with the same latency. No array access is made.
- Read-after-write: a write at T followed by a read of the same address accepted at T+1 returns the new data. Read and write never overlap in the same cycle because of write priority.
- resp_data holds its last value when no response is valid.
- Reset mid-operation: in-flight reads are dropped, with no resp_valid after reset release until a new accept.

Test Plan:
- Reset, then channel 0 requests addr 0,1,3,20 back-to-back with OUT_REG=1 -> resp_valid[0] pulses at T+2..T+5 with data 2, 5, 10, 50.
- All 4 channels hold req_valid=1 for 8 cycles -> grants in order 0,1,2,3,0,1,2,3; each channel gets exactly 2 responses, in order.
- cfg_we=1 at addr 5, data 16'h00AA, while channel 2 requests -> req_ready=0 that cycle; the channel 2 request at addr 5 next cycle returns 16'h00AA.
- Request addr 1023 with DEPTH=1000 -> returns 50. A write to addr 1010 is ignored, and a read of addr 999 still returns 50.
- Assert reset=0 one cycle after accepting a read -> resp_valid stays 0 and resp_data=0. After release the table still holds any prior writes.
- OUT_REG=0, NCH=1: continuous requests to incrementing addresses -> 1-cycle latency, one response per cycle, with no bubbles.

Source files
------------

// File: rtl/dfs_lut_mc.sv
// Multi-channel DFS frequency lookup table: round-robin arbitrated read port,
// runtime-writable saturating ramp table, optional output register stage.
module dfs_lut_mc #(
    parameter int NCH          = 4,
    parameter int ADDR_WIDTH   = 10,
    parameter int DEPTH        = 1024,
    parameter int DATA_WIDTH   = 16,
    parameter int OUT_REG      = 1,
    parameter int INIT_BASE    = 2,
    parameter int INIT_STEP_X2 = 5,
    parameter int INIT_MAX     = 50
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cfg_we,
    input  logic [ADDR_WIDTH-1:0]     cfg_addr,
    input  logic [DATA_WIDTH-1:0]     cfg_data,
    input  logic [NCH-1:0]            req_valid,
    input  logic [NCH*ADDR_WIDTH-1:0] req_addr,
    output logic [NCH-1:0]            req_ready,
    output logic [NCH-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]     resp_data
);

    localparam int                    CW      = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [DATA_WIDTH-1:0] SAT_L   = DATA_WIDTH'(INIT_MAX);

    // Handshake: a channel's request is taken in the cycle where req_valid[i] and
    // req_ready[i] are both high; req_ready is one-hot0 and never waits on req_valid
    // of other cycles. Responses have no backpressure: resp_valid is a 1-cycle pulse.

    // Saturating ramp value of an entry before any runtime write.
    function automatic logic [DATA_WIDTH-1:0] ramp(input logic [ADDR_WIDTH-1:0] a);
        longint v;
        v = longint'(INIT_BASE) + (longint'(INIT_STEP_X2) * longint'(a) + 64'sd1) / 64'sd2;
        if (v > longint'(INIT_MAX)) begin
            v = longint'(INIT_MAX);
        end
        return DATA_WIDTH'(v);
    endfunction

    // Each word stores (entry XOR ramp(index)), so the zero power-up state of the
    // array reads back as the initial ramp without any load sequence.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [CW-1:0]         ptr;
    logic [CW-1:0]         grant_idx;
    logic [CW-1:0]         ptr_next;
    logic                  grant_found;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_oor;
    logic                  cfg_in_range;

    logic                  s1_valid;
    logic [CW-1:0]         s1_ch;
    logic [DATA_WIDTH-1:0] s1_data;
    logic [NCH-1:0]        s1_onehot;

    // Round-robin search starting at the pointer, wrapping modulo NCH.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!grant_found && req_valid[(int'(ptr) + i) % NCH]) begin
                grant_found = 1'b1;
                grant_idx   = CW'((int'(ptr) + i) % NCH);
            end
        end
    end

    assign accept    = grant_found & ~cfg_we;
    assign req_ready = accept ? (NCH'(1) << grant_idx) : '0;
    assign ptr_next  = (int'(grant_idx) == NCH - 1) ? '0 : grant_idx + CW'(1);

    assign sel_addr     = req_addr[int'(grant_idx) * ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_oor      = {1'b0, sel_addr} >= DEPTH_L;
    assign cfg_in_range = {1'b0, cfg_addr} < DEPTH_L;

    // Table contents survive reset, so the array has no reset branch.
    always_ff @(posedge clk) begin
        if (cfg_we && cfg_in_range) begin
            mem[cfg_addr] <= cfg_data ^ ramp(cfg_addr);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr      <= '0;
            s1_valid <= 1'b0;
            s1_ch    <= '0;
            s1_data  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                ptr   <= ptr_next;
                s1_ch <= grant_idx;
                s1_data <= sel_oor ? SAT_L : (mem[sel_addr] ^ ramp(sel_addr));
            end
        end
    end

    assign s1_onehot = s1_valid ? (NCH'(1) << s1_ch) : '0;

    // s1_data only moves on an accept, so it already holds between responses.
    if (OUT_REG != 0) begin : g_out_reg
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                resp_valid <= '0;
                resp_data  <= '0;
            end else begin
                resp_valid <= s1_onehot;
                if (s1_valid) begin
                    resp_data <= s1_data;
                end
            end
        end
    end else begin : g_out_comb
        assign resp_valid = s1_onehot;
        assign resp_data  = s1_data;
    end

    a_grant_onehot : assert property (@(posedge clk) disable iff (!reset) $onehot0(req_ready));
    a_resp_onehot  : assert property (@(posedge clk) disable iff (!reset) $onehot0(resp_valid));

endmodule
